// File: rtl/fwd_hazard_scoreboard_if.sv
// Forwarding/hazard unit bus: ID-stage request fields in,
// stall and EX operand-select outputs back.
interface fwd_hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int SW     = $clog2(DEPTH + 1)
);
    logic              pipe_hold;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic [SW-1:0]     id_ready_stage;
    logic              ex_flush;
    logic              id_stall;
    logic [SW-1:0]     ex_fwd_a;
    logic [SW-1:0]     ex_fwd_b;
    logic              hazard_err;

    modport master (
        output pipe_hold, id_valid, id_rs1, id_rs2,
        output id_use_rs1, id_use_rs2, id_rd,
        output id_regwrite, id_ready_stage, ex_flush,
        input  id_stall, ex_fwd_a, ex_fwd_b, hazard_err
    );

    modport slave (
        input  pipe_hold, id_valid, id_rs1, id_rs2,
        input  id_use_rs1, id_use_rs2, id_rd,
        input  id_regwrite, id_ready_stage, ex_flush,
        output id_stall, ex_fwd_a, ex_fwd_b, hazard_err
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and hazard unit: tracks producers in EX and DEPTH
// post-EX stages, stalls ID on unresolved hazards, drives EX muxes.
module fwd_hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int SW     = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    fwd_hazard_scoreboard_if.slave bus
);

    typedef logic [REG_AW-1:0] reg_t;
    typedef logic [DEPTH:0][REG_AW-1:0] rd_arr_t;
    typedef logic [DEPTH:0][SW-1:0] rdy_arr_t;

    // Index 0 is the EX slot, 1..DEPTH the post-EX stages
    logic [DEPTH:0] vld_q, vld_d;
    logic [DEPTH:0] wen_q, wen_d;
    rd_arr_t        rd_q, rd_d;
    rdy_arr_t       rdy_q, rdy_d;
    reg_t           rs1_q, rs1_d;
    reg_t           rs2_q, rs2_d;
    logic           use1_q, use1_d;
    logic           use2_q, use2_d;
    logic           err_q, err_d;

    logic           stall;
    logic           load;
    logic [SW:0]    fwd_a_r;
    logic [SW:0]    fwd_b_r;

    // A consumer in ID stalls when the youngest producer in S0..S(DEPTH-1)
    // will still lack its result once the consumer reaches EX.
    function automatic logic src_stall(
        input reg_t           r,
        input logic [DEPTH:0] v,
        input logic [DEPTH:0] w,
        input rd_arr_t        rd,
        input rdy_arr_t       rdy
    );
        logic found;
        logic res;
        found = 1'b0;
        res   = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (!found && v[j] && w[j] && rd[j] == r && r != '0) begin
                found = 1'b1;
                res   = rdy[j] > SW'(j + 1);
            end
        end
        return res;
    endfunction

    // Returns {not_ready, select}; youngest matching stage wins.
    function automatic logic [SW:0] fwd_lookup(
        input reg_t           r,
        input logic [DEPTH:0] v,
        input logic [DEPTH:0] w,
        input rd_arr_t        rd,
        input rdy_arr_t       rdy
    );
        logic          found;
        logic          bad;
        logic [SW-1:0] sel;
        found = 1'b0;
        bad   = 1'b0;
        sel   = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && v[k] && w[k] && rd[k] == r && r != '0) begin
                found = 1'b1;
                if (rdy[k] <= SW'(k)) begin
                    sel = SW'(k);
                end else begin
                    bad = 1'b1;
                end
            end
        end
        return {bad, sel};
    endfunction

    // Stall request, forward selects and sticky error next state
    always_comb begin
        stall   = 1'b0;
        fwd_a_r = '0;
        fwd_b_r = '0;
        if (bus.id_valid) begin
            if (bus.id_use_rs1 &&
                src_stall(bus.id_rs1, vld_q, wen_q, rd_q, rdy_q)) begin
                stall = 1'b1;
            end
            if (bus.id_use_rs2 &&
                src_stall(bus.id_rs2, vld_q, wen_q, rd_q, rdy_q)) begin
                stall = 1'b1;
            end
        end
        if (vld_q[0] && use1_q) begin
            fwd_a_r = fwd_lookup(rs1_q, vld_q, wen_q, rd_q, rdy_q);
        end
        if (vld_q[0] && use2_q) begin
            fwd_b_r = fwd_lookup(rs2_q, vld_q, wen_q, rd_q, rdy_q);
        end
        err_d = err_q | fwd_a_r[SW] | fwd_b_r[SW];
    end

    assign bus.id_stall   = stall;
    assign bus.ex_fwd_a   = fwd_a_r[SW-1:0];
    assign bus.ex_fwd_b   = fwd_b_r[SW-1:0];
    assign bus.hazard_err = err_q;

    // Shift the tracker one stage and load or bubble the EX slot
    always_comb begin
        vld_d  = vld_q;
        wen_d  = wen_q;
        rd_d   = rd_q;
        rdy_d  = rdy_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        use1_d = use1_q;
        use2_d = use2_q;
        load   = bus.id_valid && !stall && !bus.ex_flush;
        if (!bus.pipe_hold) begin
            for (int k = 1; k <= DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                wen_d[k] = wen_q[k-1];
                rd_d[k]  = rd_q[k-1];
                rdy_d[k] = rdy_q[k-1];
            end
            vld_d[0] = load;
            if (load) begin
                wen_d[0] = bus.id_regwrite;
                rd_d[0]  = bus.id_rd;
                rdy_d[0] = bus.id_ready_stage;
                rs1_d    = bus.id_rs1;
                rs2_d    = bus.id_rs2;
                use1_d   = bus.id_use_rs1;
                use2_d   = bus.id_use_rs2;
            end
        end
    end

    // Tracker and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            wen_q  <= '0;
            rd_q   <= '0;
            rdy_q  <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            use1_q <= 1'b0;
            use2_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            wen_q  <= wen_d;
            rd_q   <= rd_d;
            rdy_q  <= rdy_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            use1_q <= use1_d;
            use2_q <= use2_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Bench for fwd_hazard_scoreboard: DEPTH=2 and DEPTH=4 instances,
// expected outputs queued per driven cycle and popped at negedge.
module tb_fwd_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic [3:0] rdy;
        logic       fl;
        logic       hold;
    } stim_t;

    typedef struct packed {
        logic       st;
        logic [3:0] fa;
        logic [3:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    fwd_hazard_scoreboard_if #(.REG_AW(5), .DEPTH(2)) b2 ();
    fwd_hazard_scoreboard_if #(.REG_AW(5), .DEPTH(4)) b4 ();

    fwd_hazard_scoreboard #(.REG_AW(5), .DEPTH(2)) u2 (
        .clk(clk), .rst(rst), .bus(b2)
    );
    fwd_hazard_scoreboard #(.REG_AW(5), .DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .bus(b4)
    );

    function automatic stim_t mk(input int v, input int rs1, input int rs2,
                                 input int u1, input int u2, input int rd,
                                 input int we, input int rdy, input int fl,
                                 input int hold);
        stim_t s;
        s.v = (v != 0);
        s.rs1 = 5'(rs1);
        s.rs2 = 5'(rs2);
        s.u1 = (u1 != 0);
        s.u2 = (u2 != 0);
        s.rd = 5'(rd);
        s.we = (we != 0);
        s.rdy = 4'(rdy);
        s.fl = (fl != 0);
        s.hold = (hold != 0);
        return s;
    endfunction

    function automatic exp_t ex(input int st, input int fa, input int fb);
        exp_t e;
        e.st = (st != 0);
        e.fa = 4'(fa);
        e.fb = 4'(fb);
        return e;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input stim_t s, input bit sel);
        if (!sel) begin
            b2.id_valid = s.v;
            b2.id_rs1 = s.rs1;
            b2.id_rs2 = s.rs2;
            b2.id_use_rs1 = s.u1;
            b2.id_use_rs2 = s.u2;
            b2.id_rd = s.rd;
            b2.id_regwrite = s.we;
            b2.id_ready_stage = s.rdy[1:0];
            b2.ex_flush = s.fl;
            b2.pipe_hold = s.hold;
        end else begin
            b4.id_valid = s.v;
            b4.id_rs1 = s.rs1;
            b4.id_rs2 = s.rs2;
            b4.id_use_rs1 = s.u1;
            b4.id_use_rs2 = s.u2;
            b4.id_rd = s.rd;
            b4.id_regwrite = s.we;
            b4.id_ready_stage = s.rdy[2:0];
            b4.ex_flush = s.fl;
            b4.pipe_hold = s.hold;
        end
    endtask

    function automatic exp_t obs(input bit sel);
        exp_t g;
        if (!sel) begin
            g.st = b2.id_stall;
            g.fa = 4'(b2.ex_fwd_a);
            g.fb = 4'(b2.ex_fwd_b);
        end else begin
            g.st = b4.id_stall;
            g.fa = 4'(b4.ex_fwd_a);
            g.fb = 4'(b4.ex_fwd_b);
        end
        return g;
    endfunction

    task automatic test_reset();
        exp_t g;
        drive(mk(1, 9, 5, 1, 1, 3, 1, 1, 0, 0), 1'b1);
        #1;
        g = obs(1'b0);
        total++;
        if (g !== ex(0, 0, 0)) begin
            bad++;
            $display("FAIL reset_d2: got %h want 0", g);
        end
        g = obs(1'b1);
        total++;
        if (g !== ex(0, 0, 0)) begin
            bad++;
            $display("FAIL reset_d4: got %h want 0", g);
        end
        total++;
        if ({b2.hazard_err, b4.hazard_err} !== 2'b00) begin
            bad++;
            $display("FAIL reset_err: got %b%b want 00",
                     b2.hazard_err, b4.hazard_err);
        end
        drive(idle(), 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_fwd();
        stim_t s[5];
        exp_t  e[5];
        exp_t  g, x;
        s = '{mk(1, 1, 2, 1, 1, 5, 1, 1, 0, 0),
              mk(1, 5, 7, 1, 1, 6, 1, 1, 0, 0),
              idle(), idle(), idle()};
        e = '{ex(0, 0, 0), ex(0, 0, 0), ex(0, 1, 0),
              ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 5; i++) begin
            drive(s[i], 1'b0);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b0);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL alu_fwd[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_load_use();
        stim_t s[6];
        exp_t  e[6];
        exp_t  g, x;
        s = '{mk(1, 1, 0, 1, 0, 5, 1, 2, 0, 0),
              mk(1, 5, 5, 1, 1, 6, 1, 1, 0, 0),
              mk(1, 5, 5, 1, 1, 6, 1, 1, 0, 0),
              idle(), idle(), idle()};
        e = '{ex(0, 0, 0), ex(1, 0, 0), ex(0, 0, 0),
              ex(0, 2, 2), ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            drive(s[i], 1'b0);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b0);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL load_use[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_double_hazard();
        stim_t s[6];
        exp_t  e[6];
        exp_t  g, x;
        s = '{mk(1, 1, 0, 1, 0, 3, 1, 1, 0, 0),
              mk(1, 2, 0, 1, 0, 3, 1, 1, 0, 0),
              mk(1, 3, 0, 1, 1, 4, 1, 1, 0, 0),
              idle(), idle(), idle()};
        e = '{ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0),
              ex(0, 1, 0), ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 6; i++) begin
            drive(s[i], 1'b0);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b0);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL double_hazard[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_x0();
        stim_t s[4];
        exp_t  e[4];
        exp_t  g, x;
        s = '{mk(1, 1, 0, 1, 0, 0, 1, 2, 0, 0),
              mk(1, 0, 0, 1, 1, 6, 1, 1, 0, 0),
              idle(), idle()};
        e = '{ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 4; i++) begin
            drive(s[i], 1'b0);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b0);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL x0[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (b2.hazard_err !== 1'b0) begin
            bad++;
            $display("FAIL x0_err: got %b want 0", b2.hazard_err);
        end
    endtask

    task automatic test_flush_stall();
        stim_t s[7];
        exp_t  e[7];
        exp_t  g, x;
        s = '{mk(1, 1, 0, 1, 0, 5, 1, 2, 0, 0),
              mk(1, 5, 7, 1, 0, 6, 1, 1, 1, 0),
              mk(1, 5, 7, 1, 0, 6, 1, 1, 0, 0),
              idle(),
              mk(1, 6, 0, 1, 0, 8, 1, 1, 1, 0),
              idle(), idle()};
        e = '{ex(0, 0, 0), ex(1, 0, 0), ex(0, 0, 0), ex(0, 2, 0),
              ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 7; i++) begin
            drive(s[i], 1'b0);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b0);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL flush_stall[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_multicycle();
        stim_t s[20];
        exp_t  e[20];
        exp_t  g, x;
        stim_t mul, use9, ind;
        mul  = mk(1, 1, 2, 1, 1, 9, 1, 4, 0, 0);
        use9 = mk(1, 9, 0, 1, 0, 10, 1, 1, 0, 0);
        ind  = mk(1, 1, 0, 1, 0, 11, 1, 1, 0, 0);
        s = '{mul, use9, use9, use9, use9, idle(), idle(), idle(),
              idle(), idle(),
              mul, ind, use9, use9, use9, idle(), idle(), idle(),
              idle(), idle()};
        e = '{ex(0, 0, 0), ex(1, 0, 0), ex(1, 0, 0), ex(1, 0, 0),
              ex(0, 0, 0), ex(0, 4, 0), ex(0, 0, 0), ex(0, 0, 0),
              ex(0, 0, 0), ex(0, 0, 0),
              ex(0, 0, 0), ex(0, 0, 0), ex(1, 0, 0), ex(1, 0, 0),
              ex(0, 0, 0), ex(0, 4, 0), ex(0, 0, 0), ex(0, 0, 0),
              ex(0, 0, 0), ex(0, 0, 0)};
        for (int i = 0; i < 20; i++) begin
            drive(s[i], 1'b1);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b1);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL multicycle[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hold();
        stim_t s[13];
        exp_t  e[13];
        exp_t  g, x;
        stim_t mul, use9, use9h;
        mul   = mk(1, 1, 2, 1, 1, 9, 1, 4, 0, 0);
        use9  = mk(1, 9, 0, 1, 0, 10, 1, 1, 0, 0);
        use9h = mk(1, 9, 0, 1, 0, 10, 1, 1, 0, 1);
        s = '{mul, use9, use9h, use9h, use9h, use9, use9, use9,
              idle(), idle(), idle(), idle(), idle()};
        e = '{ex(0, 0, 0), ex(1, 0, 0), ex(1, 0, 0), ex(1, 0, 0),
              ex(1, 0, 0), ex(1, 0, 0), ex(1, 0, 0), ex(0, 0, 0),
              ex(0, 4, 0), ex(0, 0, 0), ex(0, 0, 0), ex(0, 0, 0),
              ex(0, 0, 0)};
        for (int i = 0; i < 13; i++) begin
            drive(s[i], 1'b1);
            expq.push_back(e[i]);
            @(negedge clk);
            g = obs(1'b1);
            x = expq.pop_front();
            total++;
            if (g !== x) begin
                bad++;
                $display("FAIL hold[%0d]: got st=%0b a=%0d b=%0d want st=%0b a=%0d b=%0d",
                         i, g.st, g.fa, g.fb, x.st, x.fa, x.fb);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_rst();
        drive(mk(1, 1, 2, 1, 1, 5, 1, 1, 0, 0), 1'b0);
        drive(idle(), 1'b1);
        @(posedge clk);
        #1;
        drive(mk(1, 5, 7, 1, 1, 6, 1, 1, 0, 0), 1'b0);
        drive(mk(1, 1, 2, 1, 1, 9, 1, 4, 0, 0), 1'b1);
        @(posedge clk);
        #1;
        drive(idle(), 1'b0);
        drive(mk(1, 9, 0, 1, 0, 10, 1, 1, 0, 0), 1'b1);
        @(negedge clk);
        total++;
        if (b2.ex_fwd_a !== 2'd1) begin
            bad++;
            $display("FAIL pre_rst_fwd: got %0d want 1", b2.ex_fwd_a);
        end
        total++;
        if (b4.id_stall !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_stall: got %b want 1", b4.id_stall);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (b2.ex_fwd_a !== 2'd0) begin
            bad++;
            $display("FAIL rst_fwd: got %0d want 0", b2.ex_fwd_a);
        end
        total++;
        if (b4.id_stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall: got %b want 0", b4.id_stall);
        end
        total++;
        if ({b2.hazard_err, b4.hazard_err} !== 2'b00) begin
            bad++;
            $display("FAIL rst_err: got %b%b want 00",
                     b2.hazard_err, b4.hazard_err);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (b4.id_stall !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_stall: got %b want 0", b4.id_stall);
        end
        drive(idle(), 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(idle(), 1'b0);
        drive(idle(), 1'b1);
        #2;
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_double_hazard();
        test_x0();
        test_flush_stall();
        test_multicycle();
        test_hold();
        test_async_rst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_scoreboard.md
Name: fwd_hazard_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the pipelined RISC-V core.
- Generalises two-stage EX/MEM and MEM/WB forwarding to DEPTH post-EX stages.
- Each producer carries a result-ready stage, so loads and multi-cycle ops forward only once their data exists.
- Tracks in-flight producers internally, raises an ID-stage stall on unresolvable hazards, and drives EX operand-mux selects.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- DEPTH, 2, number of post-EX stages (1 = EX/MEM, DEPTH = WB); legal range 2..8.
- SW, $clog2(DEPTH+1), width of stage indices and forward selects (derived, do not override).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- pipe_hold  in  1  global freeze (e.g. memory wait); the tracker does not advance
- id_valid  in  1  ID holds a valid instruction
- id_rs1  in  REG_AW  ID source 1
- id_rs2  in  REG_AW  ID source 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_rd  in  REG_AW  ID destination
- id_regwrite  in  1  instruction writes rd
- id_ready_stage  in  SW  first post-EX stage holding the result (1 = ALU, 2 = load, up to DEPTH)
- ex_flush  in  1  kill the instruction entering EX (branch or jump redirect)
- id_stall  out  1  hold PC and IF/ID; insert a bubble into EX
- ex_fwd_a  out  SW  operand A select: 0 = ID/EX register value, k = stage k result
- ex_fwd_b  out  SW  operand B select, same encoding
- hazard_err  out  1  sticky; set if EX needs a not-ready producer

Behaviour:
- State: EX slot S0 holds {valid, rs1, rs2, use1, use2, rd, wen, rdy}. Stages S1..SDEPTH each hold {valid, rd, wen, rdy}.
- Reset (async, on rst high): all valid bits 0 and hazard_err 0. With all entries invalid, id_stall = 0 and ex_fwd_a = ex_fwd_b = 0.
- Producer match: an entry matches source r when valid && wen && rd == r && r != 0.
- Stall (combinational, 0-cycle): id_stall = 1 iff id_valid and, for a used source, the youngest matching entry among S0..SDEPTH-1 at index j has rdy > j+1. The test uses the position the producer will occupy when the consumer reaches EX.
  - A matching SDEPTH entry never stalls; the register file is write-first.
  - Only the youngest matching entry is evaluated; older matches are ignored.
- Advance on the rising clk edge when pipe_hold = 0:
  - Stage k takes stage k-1 for k = 1..DEPTH; SDEPTH's old content retires.
  - S0 loads the ID fields when id_valid && !id_stall && !ex_flush; otherwise S0.valid becomes 0 (bubble).
  - ex_flush has priority over stall; both give a bubble, and id_stall is still reported.
- pipe_hold = 1: all state holds. id_stall and ex_fwd still evaluate combinationally on the held state.
- Forward select (combinational from state), for each used source of a valid S0:
  - Find the youngest matching stage k in 1..DEPTH.
  - If found and rdy <= k, the select is k. If there is no match, the select is 0.
  - If found and rdy > k, the select is 0 and hazard_err sets at the next edge; it clears only on rst.
  - An unused source, or S0.valid = 0, gives select 0.
- Youngest wins: S1 over S2 over … SDEPTH (standard double-hazard priority).
- rd = 0 producers never forward and never stall.
- Self-dependency: the consumer's own rd is irrelevant to its own sources.
- Reset mid-operation drops all in-flight tracking immediately; no bubble replay is needed.

Test Plan:
- DEPTH=2, ALU `add x5` (rdy 1) then `sub x6,x5,x7` back-to-back -> id_stall stays 0; on the cycle the sub is in EX, ex_fwd_a = 1.
- DEPTH=2, `lw x5` (rdy 2) then `add x6,x5,x5` -> id_stall = 1 for exactly one cycle, with a bubble in S0; then ex_fwd_a = ex_fwd_b = 2.
- Double hazard, DEPTH=2: `addi x3` (S2) and `addi x3` (S1) both in flight, consumer reads x3 -> ex_fwd_a = 1 (youngest).
- DEPTH=4, multi-cycle op writing x9 with rdy 4, followed by consumer of x9:
  - id_stall = 1 for 3 cycles, then ex_fwd = 4.
  - With one independent instruction in between: 2 stall cycles.
- Write to x0 with rdy 2, then consumer of x0 -> no stall, ex_fwd = 0.
- Stall coincident with ex_flush -> S0 is a bubble, ID is held.
- pipe_hold asserted for 3 cycles mid-stall -> state is frozen and the stall count resumes afterwards.
- Assert rst between edges -> outputs are 0 immediately and hazard_err is cleared.
